// File: rtl/ub_dequant_reader_if.sv
// Stream bundle for ub_dequant_reader: run control, unified-buffer read port and dequantized output stream.
// The slave side is the reader itself; the master side is whoever drives runs, backs the UB and consumes results.
interface ub_dequant_reader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic [15:0]       dq_scale;
  logic [7:0]        dq_zero_point;
  logic              busy;
  logic              done;
  logic              ub_rd_en;
  logic [ADDR_W-1:0] ub_rd_addr;
  logic [7:0]        ub_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              out_last;

  modport master (
    output start, base_addr, length, dq_scale, dq_zero_point, ub_rd_data, out_ready,
    input  busy, done, ub_rd_en, ub_rd_addr, out_valid, out_data, out_last
  );

  modport slave (
    input  start, base_addr, length, dq_scale, dq_zero_point, ub_rd_data, out_ready,
    output busy, done, ub_rd_en, ub_rd_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ub_dequant_reader.sv
// Streams int8 words out of the unified buffer, dequantizes them as round((q - zp) * S) with S in Q8.8,
// and hands them downstream through a credit-protected output FIFO.
module ub_dequant_reader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input logic               clk,
  input logic               reset_n,
  ub_dequant_reader_if.slave io_bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [PW-1:0]     PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_rdEn;
  logic [ADDR_W-1:0]   r_rdAddr;
  logic [ADDR_W-1:0]   r_nextAddr;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_issued;
  logic [ADDR_W:0]     r_popped;
  logic signed [15:0]  r_scale;
  logic signed [7:0]   r_zp;
  logic [CW-1:0]       r_credit;

  logic                r_v0;
  logic                r_v1;
  logic                r_v2;
  logic signed [8:0]   r_d;
  logic signed [24:0]  r_p;
  logic [31:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wPtr;
  logic [PW-1:0]       r_rPtr;
  logic [CW-1:0]       r_count;

  logic                w_outValid;
  logic                w_pop;
  logic                w_lastHead;
  logic [CW-1:0]       w_creditAfterPop;
  logic                w_canIssue;
  logic signed [8:0]   w_d;
  logic signed [24:0]  w_dExt;
  logic signed [24:0]  w_sExt;
  logic signed [24:0]  w_sum;
  logic signed [24:0]  w_shift;
  logic [31:0]         w_result;

  assign w_outValid       = (r_count != '0);
  assign w_pop            = w_outValid && io_bus.out_ready;
  assign w_lastHead       = (r_popped == r_len - LEN_ONE);
  // A credit is held from issue until the word leaves the FIFO, so every read owns a slot.
  assign w_creditAfterPop = r_credit - CW'(w_pop);
  assign w_canIssue       = (r_state == RUN) && (w_creditAfterPop < CW'(FIFO_DEPTH));

  assign w_d      = {io_bus.ub_rd_data[7], io_bus.ub_rd_data} - {r_zp[7], r_zp};
  assign w_dExt   = {{16{r_d[8]}}, r_d};
  assign w_sExt   = {{9{r_scale[15]}}, r_scale};
  assign w_sum    = r_p + 25'sd128;
  assign w_shift  = w_sum >>> 8;
  assign w_result = {{7{w_shift[24]}}, w_shift};

  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.ub_rd_en   = r_rdEn;
  assign io_bus.ub_rd_addr = r_rdAddr;
  assign io_bus.out_valid  = w_outValid;
  assign io_bus.out_data   = w_outValid ? r_mem[r_rPtr] : 32'd0;
  assign io_bus.out_last   = w_outValid && w_lastHead;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rdEn     <= 1'b0;
      r_rdAddr   <= '0;
      r_nextAddr <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_popped   <= '0;
      r_scale    <= '0;
      r_zp       <= '0;
      r_credit   <= '0;
    end else begin
      r_done   <= 1'b0;
      r_rdEn   <= 1'b0;
      r_credit <= r_credit + CW'(w_canIssue) - CW'(w_pop);
      if (w_pop) begin
        r_popped <= r_popped + LEN_ONE;
      end
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            r_len      <= io_bus.length;
            r_nextAddr <= io_bus.base_addr;
            r_scale    <= io_bus.dq_scale;
            r_zp       <= io_bus.dq_zero_point;
            r_issued   <= '0;
            r_popped   <= '0;
            r_busy     <= 1'b1;
            if (io_bus.length == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (w_canIssue) begin
            r_rdEn     <= 1'b1;
            r_rdAddr   <= r_nextAddr;
            r_nextAddr <= r_nextAddr + ADDR_ONE;
            r_issued   <= r_issued + LEN_ONE;
            if (r_issued == r_len - LEN_ONE) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_pop && w_lastHead) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Fixed-latency datapath: data arrives, subtract zp, multiply by S, round and push into the FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_d     <= '0;
      r_p     <= '0;
      r_wPtr  <= '0;
      r_rPtr  <= '0;
      r_count <= '0;
    end else begin
      r_v0 <= r_rdEn;
      r_v1 <= r_v0;
      r_v2 <= r_v1;
      if (r_v0) begin
        r_d <= w_d;
      end
      if (r_v1) begin
        r_p <= w_dExt * w_sExt;
      end
      if (r_v2) begin
        r_mem[r_wPtr] <= w_result;
        r_wPtr        <= r_wPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rPtr <= r_rPtr + PTR_ONE;
      end
      r_count <= r_count + CW'(r_v2) - CW'(w_pop);
    end
  end
endmodule
